// File: rtl/instruction_loader.sv
// Byte-stream program loader: assembles big-endian words and writes them to instruction memory while holding the CPU.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data.
module instruction_loader #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Start,
   input  logic [7:0]  ByteIn,
   input  logic        ByteValid,
   output logic        ByteReady,
   output logic        WriteEnable,
   output logic [31:0] WriteAddress,
   output logic [31:0] WriteData,
   output logic        CpuHold,
   output logic        LoadDone,
   output logic        LoadError,
   output logic [10:0] WordCount
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_HI = 3'd1,
      ST_LEN_LO = 3'd2,
      ST_BYTES  = 3'd3,
      ST_WRITE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
      ST_CHECK  = 3'd5,
`endif
      ST_DONE   = 3'd6
   } state_t;

   // After the final word (or an empty program) the next stop is CHECK when checksums are enabled.
`ifdef LOADER_CHECKSUM_EN
   localparam state_t ST_FINISH = ST_CHECK;
`else
   localparam state_t ST_FINISH = ST_DONE;
`endif

   state_t      state_r, state_s;
   logic [15:0] len_r, len_s;
   logic [23:0] shift_r, shift_s;
   logic [1:0]  cnt_r, cnt_s;
   logic [10:0] wc_r, wc_s;
   logic        err_r, err_s;
   logic        we_r, we_s;
   logic [31:0] wa_r, wa_s;
   logic [31:0] wd_r, wd_s;
   logic        ready_r, ready_s;
   logic        hold_r, hold_s;
   logic        done_r, done_s;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  csum_r, csum_s;
`endif

   logic        xfer_s;
   logic [15:0] len_full_s;
   logic [10:0] wc_inc_s;

   assign xfer_s     = ByteValid && ready_r;
   assign len_full_s = {len_r[15:8], ByteIn};
   assign wc_inc_s   = wc_r + 11'd1;

   // Next-state and next-output decode.
   always_comb begin
      state_s = state_r;
      len_s   = len_r;
      shift_s = shift_r;
      cnt_s   = cnt_r;
      wc_s    = wc_r;
      err_s   = err_r;
      we_s    = 1'b0;
      wa_s    = wa_r;
      wd_s    = wd_r;
`ifdef LOADER_CHECKSUM_EN
      csum_s  = csum_r;
`endif
      case (state_r)
         ST_IDLE, ST_DONE: begin
            if (Start) begin
               state_s = ST_LEN_HI;
               len_s   = 16'd0;
               shift_s = 24'd0;
               cnt_s   = 2'd0;
               wc_s    = 11'd0;
               err_s   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
               csum_s  = 8'd0;
`endif
            end else begin
               state_s = state_r;
            end
         end
         ST_LEN_HI: begin
            if (xfer_s) begin
               len_s   = {ByteIn, len_r[7:0]};
               state_s = ST_LEN_LO;
            end else begin
               state_s = ST_LEN_HI;
            end
         end
         ST_LEN_LO: begin
            if (xfer_s) begin
               len_s = len_full_s;
               if (len_full_s == 16'd0) begin
                  state_s = ST_FINISH;
               end else if ({1'b0, len_full_s} > 17'(DEPTH)) begin
                  state_s = ST_DONE;
                  err_s   = 1'b1;
               end else begin
                  state_s = ST_BYTES;
               end
            end else begin
               state_s = ST_LEN_LO;
            end
         end
         ST_BYTES: begin
            if (xfer_s) begin
               shift_s = {shift_r[15:0], ByteIn};
               cnt_s   = cnt_r + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               csum_s  = csum_r ^ ByteIn;
`endif
               if (cnt_r == 2'd3) begin
                  state_s = ST_WRITE;
                  we_s    = 1'b1;
                  wd_s    = {shift_r, ByteIn};
                  wa_s    = BASE_ADDR + {19'd0, wc_r, 2'b00};
               end else begin
                  state_s = ST_BYTES;
               end
            end else begin
               state_s = ST_BYTES;
            end
         end
         ST_WRITE: begin
            wc_s = wc_inc_s;
            if ({5'd0, wc_inc_s} == len_r) begin
               state_s = ST_FINISH;
            end else begin
               state_s = ST_BYTES;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            if (xfer_s) begin
               err_s   = (ByteIn != csum_r);
               state_s = ST_DONE;
            end else begin
               state_s = ST_CHECK;
            end
         end
`endif
         default: begin
            state_s = ST_IDLE;
         end
      endcase

      // Status outputs are registered from the state being entered.
      case (state_s)
         ST_LEN_HI, ST_LEN_LO, ST_BYTES: begin
            ready_s = 1'b1;
            hold_s  = 1'b1;
            done_s  = 1'b0;
         end
`ifdef LOADER_CHECKSUM_EN
         ST_CHECK: begin
            ready_s = 1'b1;
            hold_s  = 1'b1;
            done_s  = 1'b0;
         end
`endif
         ST_WRITE: begin
            ready_s = 1'b0;
            hold_s  = 1'b1;
            done_s  = 1'b0;
         end
         ST_DONE: begin
            ready_s = 1'b0;
            hold_s  = 1'b0;
            done_s  = 1'b1;
         end
         default: begin
            ready_s = 1'b0;
            hold_s  = 1'b0;
            done_s  = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_r <= ST_IDLE;
         len_r   <= 16'd0;
         shift_r <= 24'd0;
         cnt_r   <= 2'd0;
         wc_r    <= 11'd0;
         err_r   <= 1'b0;
         we_r    <= 1'b0;
         wa_r    <= 32'd0;
         wd_r    <= 32'd0;
         ready_r <= 1'b0;
         hold_r  <= 1'b0;
         done_r  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_r  <= 8'd0;
`endif
      end else begin
         state_r <= state_s;
         len_r   <= len_s;
         shift_r <= shift_s;
         cnt_r   <= cnt_s;
         wc_r    <= wc_s;
         err_r   <= err_s;
         we_r    <= we_s;
         wa_r    <= wa_s;
         wd_r    <= wd_s;
         ready_r <= ready_s;
         hold_r  <= hold_s;
         done_r  <= done_s;
`ifdef LOADER_CHECKSUM_EN
         csum_r  <= csum_s;
`endif
      end
   end

   assign ByteReady    = ready_r;
   assign WriteEnable  = we_r;
   assign WriteAddress = wa_r;
   assign WriteData    = wd_r;
   assign CpuHold      = hold_r;
   assign LoadDone     = done_r;
   assign LoadError    = err_r;
   assign WordCount    = wc_r;

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: expected writes are queued by the stimulus and checked by a monitor.
module tb_instruction_loader;

   localparam logic [31:0] TB_BASE  = 32'h0000_0100;
   localparam int          TB_DEPTH = 1024;

   logic        Clk = 1'b0;
   logic        Reset = 1'b0;
   logic        Start = 1'b0;
   logic [7:0]  ByteIn = 8'd0;
   logic        ByteValid = 1'b0;
   logic        ByteReady;
   logic        WriteEnable;
   logic [31:0] WriteAddress;
   logic [31:0] WriteData;
   logic        CpuHold;
   logic        LoadDone;
   logic        LoadError;
   logic [10:0] WordCount;

   int tests = 0;
   int fails = 0;
   logic [63:0] exp_q[$];
   logic [31:0] prog[TB_DEPTH];

   instruction_loader #(.DEPTH(TB_DEPTH), .BASE_ADDR(TB_BASE)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
      .ByteReady(ByteReady), .WriteEnable(WriteEnable), .WriteAddress(WriteAddress),
      .WriteData(WriteData), .CpuHold(CpuHold), .LoadDone(LoadDone), .LoadError(LoadError),
      .WordCount(WordCount)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the scoreboard.
   always @(negedge Clk) begin
      if (WriteEnable === 1'b1) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_write: got addr=%h data=%h expected no write", WriteAddress, WriteData);
         end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            chk("write_addr", WriteAddress, e[63:32]);
            chk("write_data", WriteData, e[31:0]);
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      ByteIn = b;
      ByteValid = 1'b1;
      while (ByteReady !== 1'b1 && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("byte_ready_timeout", 32'(ByteReady), 32'd1);
      tick();
      ByteValid = 1'b0;
   endtask

   task automatic pulse_start();
      Start = 1'b1;
      tick();
      Start = 1'b0;
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (LoadDone !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      chk("load_done", 32'(LoadDone), 32'd1);
   endtask

   function automatic logic [7:0] xor_words(input int n);
      logic [7:0] x;
      x = 8'd0;
      for (int i = 0; i < n; i++) x = x ^ prog[i][31:24] ^ prog[i][23:16] ^ prog[i][15:8] ^ prog[i][7:0];
      return x;
   endfunction

   // Loads prog[0..n-1]; gap = idle cycles after each data byte; glitch pulses Start mid-word.
   task automatic load(input int n, input int gap, input bit glitch, input logic [7:0] csum, input bit exp_err);
      logic [15:0] len;
      len = 16'(n);
      pulse_start();
      chk("cpu_hold_start", 32'(CpuHold), 32'd1);
      chk("load_done_clr", 32'(LoadDone), 32'd0);
      send_byte(len[15:8]);
      send_byte(len[7:0]);
      for (int w = 0; w < n; w++) begin
         exp_q.push_back({TB_BASE + 32'(4 * w), prog[w]});
         for (int b = 0; b < 4; b++) begin
            send_byte(prog[w][31 - 8 * b -: 8]);
            for (int g = 0; g < gap; g++) begin
               if (b < 3) chk("ready_in_stall", 32'(ByteReady), 32'd1);
               tick();
            end
            if (glitch && w == 1 && b == 1) begin
               pulse_start();
               chk("glitch_ready", 32'(ByteReady), 32'd1);
               chk("glitch_hold", 32'(CpuHold), 32'd1);
            end
         end
      end
`ifdef LOADER_CHECKSUM_EN
      send_byte(csum);
`else
      if (csum != csum) chk("unused_csum", 32'd0, 32'd0);
`endif
      wait_done();
      chk("load_error", 32'(LoadError), 32'(exp_err));
      chk("word_count", 32'(WordCount), 32'(n));
      chk("cpu_hold_done", 32'(CpuHold), 32'd0);
      chk("pending_writes", 32'(exp_q.size()), 32'd0);
      if (n > 0) chk("data_hold", WriteData, prog[n - 1]);
   endtask

   task automatic length_only(input logic [7:0] hi, input logic [7:0] lo, input bit exp_err);
      pulse_start();
      send_byte(hi);
      send_byte(lo);
`ifdef LOADER_CHECKSUM_EN
      if (!exp_err) send_byte(8'h00);
`endif
      wait_done();
      chk("len_error", 32'(LoadError), 32'(exp_err));
      chk("len_word_count", 32'(WordCount), 32'd0);
      chk("len_cpu_hold", 32'(CpuHold), 32'd0);
   endtask

   task automatic check_reset_outputs();
      chk("rst_ready", 32'(ByteReady), 32'd0);
      chk("rst_we", 32'(WriteEnable), 32'd0);
      chk("rst_waddr", WriteAddress, 32'd0);
      chk("rst_wdata", WriteData, 32'd0);
      chk("rst_hold", 32'(CpuHold), 32'd0);
      chk("rst_done", 32'(LoadDone), 32'd0);
      chk("rst_err", 32'(LoadError), 32'd0);
      chk("rst_wc", 32'(WordCount), 32'd0);
   endtask

   initial begin
      repeat (3) tick();
      check_reset_outputs();
      Reset = 1'b1;
      tick();

      // Reset mid-BYTES after two data bytes: nothing may be written.
      pulse_start();
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'hAB);
      send_byte(8'hCD);
      Reset = 1'b0;
      tick();
      tick();
      check_reset_outputs();
      Reset = 1'b1;
      tick();
      tick();
      chk("no_write_after_reset", 32'(WriteEnable), 32'd0);

      // Two-word program, continuous stream.
      prog[0] = 32'h2008_0005;
      prog[1] = 32'h0000_0000;
      load(2, 0, 1'b0, xor_words(2), 1'b0);

      // Same program with ByteValid stalls.
      load(2, 2, 1'b0, xor_words(2), 1'b0);

      // Length boundaries.
      length_only(8'h04, 8'h01, 1'b1);
      length_only(8'h00, 8'h00, 1'b0);

      // Three words with a Start pulse in the middle of the second word.
      prog[0] = 32'h1122_3344;
      prog[1] = 32'hA5A5_A5A5;
      prog[2] = 32'hDEAD_BEEF;
      load(3, 1, 1'b1, xor_words(3), 1'b0);

      // Exactly DEPTH words is legal.
      for (int i = 0; i < TB_DEPTH; i++) prog[i] = {16'(i), ~16'(i)};
      load(TB_DEPTH, 0, 1'b0, xor_words(TB_DEPTH), 1'b0);
      chk("last_addr", WriteAddress, TB_BASE + 32'h0000_0FFC);

`ifdef LOADER_CHECKSUM_EN
      prog[0] = 32'h1234_5678;
      load(1, 0, 1'b0, 8'h08, 1'b0);
      load(1, 0, 1'b0, 8'h09, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
- Writer-side counterpart to the hard-coded, read-only instruction memory.
- Receives a program as a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Issues one word write per assembled word on a write port addressed the same way the fetch side reads: byte address, bits [11:2] index the word.
- Holds the CPU off (CpuHold) while loading, so a program can be replaced without re-synthesising the memory image.

Parameters:
- DEPTH, 1024, number of 32-bit words in the target memory; longest legal program.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on the rising edge of Clk.
- Start  input  1  single-cycle request to begin a load; honoured only in IDLE or DONE.
- ByteIn  input  8  incoming stream byte.
- ByteValid  input  1  ByteIn is valid this cycle.
- ByteReady  output  1  loader accepts a byte this cycle; transfer occurs when ByteValid && ByteReady.
- WriteEnable  output  1  single-cycle word write strobe.
- WriteAddress  output  32  byte address of the write, word-aligned.
- WriteData  output  32  assembled word.
- CpuHold  output  1  high while a load is in progress.
- LoadDone  output  1  load finished (success or error).
- LoadError  output  1  valid when LoadDone is high.
- WordCount  output  11  words written in the current or last load.

Behaviour:
- Reset (Reset==0 at edge):
  - state returns to IDLE.
  - All outputs are 0; internal byte shift register, byte counter and length are cleared.
  - A reset in any state aborts immediately. A partially assembled word is never written.
- States: IDLE, LEN_HI, LEN_LO, BYTES, WRITE, DONE.
- IDLE: ByteReady=0, CpuHold=0. Start moves to LEN_HI and sets CpuHold=1, WordCount=0, LoadDone=0, LoadError=0.
- LEN_HI / LEN_LO:
  - ByteReady=1. Each accepted byte fills the 16-bit length (words), high byte first.
  - On the LEN_LO transfer:
    - length==0: go to DONE, LoadError=0, no writes.
    - length>DEPTH: go to DONE, LoadError=1, no writes.
    - otherwise: go to BYTES.
- BYTES:
  - ByteReady=1. Accepted bytes shift in MSB-first: first byte lands in [31:24], fourth in [7:0].
  - The transfer of the fourth byte moves to WRITE.
  - Cycles with ByteValid=0 are stalls; there is no timeout.
- WRITE (exactly one cycle):
  - ByteReady=0, WriteEnable=1, WriteData=assembled word, WriteAddress=BASE_ADDR + 4*WordCount.
  - At the edge, WordCount increments.
  - Next state is DONE if the new WordCount equals length, else BYTES.
  - Latency: WriteEnable asserts the cycle after the fourth byte's transfer edge.
- DONE:
  - ByteReady=0, LoadDone=1, CpuHold=0; WordCount and LoadError hold.
  - Start re-enters LEN_HI with the same clears as IDLE.
- Start while in LEN_HI, LEN_LO, BYTES or WRITE is ignored.
- WriteEnable is 0 outside WRITE. WriteAddress and WriteData hold their last values outside WRITE.
- Address arithmetic is 32-bit with wrap-around; no range check beyond the DEPTH length check.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, the loader enters an extra CHECK state with ByteReady=1 and accepts one byte.
  - That byte is compared to the running XOR of all data bytes; length bytes are excluded.
  - Mismatch sets LoadError=1; match leaves LoadError=0. Either way the next state is DONE.
  - Words already written are not rolled back.
  - length==0 also goes through CHECK, with an expected value of 8'h00.
- Undefined: no CHECK state, no checksum logic; last WRITE goes directly to DONE.

Test Plan:
- Reset held low 2 cycles mid-BYTES after 2 data bytes -> IDLE, all outputs 0, no WriteEnable seen; a fresh Start loads correctly.
- Start, stream 00 02 | 20 08 00 05 | 00 00 00 00 with ByteValid always 1 -> writes 32'h20080005 @0x0 then 32'h00000000 @0x4; LoadDone=1, LoadError=0, WordCount=2, CpuHold falls with LoadDone.
- Same stream with ByteValid toggled 1,0,0,1,... -> identical writes; ByteReady never drops in BYTES; exactly one WriteEnable per word.
- Length bytes 04 01 with DEPTH=1024 -> DONE, LoadError=1, WordCount=0, no writes. Length 00 00 -> DONE, LoadError=0.
- BASE_ADDR=32'h100, 3 words -> addresses 0x100, 0x104, 0x108. Start pulsed during BYTES -> no effect.
- LOADER_CHECKSUM_EN, words 12345678, then checksum byte 08 -> LoadError=0. Checksum byte 09 -> LoadError=1, word still written.
